apb_mem_slave: RTL and testbench

APB3 completer that converts APB read/write transfers into single-cycle `mem_read`/`mem_write` strobes for the 256×8 `datamem` scratch memory, and returns read data and status to the APB requester. It sits directly upstream of `datamem`: its memory-side outputs drive the `datamem` ports one-to-one. It adds a programmable number of wait states and address-range error reporting.

---
 rtl/apb_mem_slave_pkg.sv | 9 +
 rtl/apb_mem_slave_if.sv | 26 ++
 rtl/apb_mem_slave.sv | 139 +++++++++++++
 tb/tb_apb_mem_slave.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mem_slave_pkg.sv
// Shared types and default widths for the APB-to-datamem completer.
package apb_mem_pkg;

   localparam int unsigned APB_ADDR_W = 8;
   localparam int unsigned APB_DATA_W = 8;

   typedef enum logic [1:0] {IDLE, WAIT, MEM, RESP} apb_mem_state_t;

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB3 requester/completer signal bundle for apb_mem_slave.
interface apb_mem_slave_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);

   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              pready;
   logic [DATA_W-1:0] prdata;
   logic              pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output pready, prdata, pslverr
   );

endinterface

// File: rtl/apb_mem_slave.sv
// APB3 completer turning transfers into single-cycle datamem strobes,
// with programmable wait states and out-of-range error responses.
module apb_mem_slave
   import apb_mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = APB_ADDR_W,
   parameter int unsigned DATA_W      = APB_DATA_W,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned MEM_DEPTH   = 256
) (
   input  logic              clk,
   input  logic              rst,
   apb_mem_slave_if.slave    apb,
   output logic [ADDR_W-1:0] read_addr,
   output logic [ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0] write_data,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] read_data
);

   localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   apb_mem_state_t    state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              write_q;
   logic              err_q;
   logic              pready_q;
   logic              pslverr_q;
   logic [DATA_W-1:0] prdata_q;
   logic              mem_write_q;
   logic              mem_read_q;
   logic [ADDR_W-1:0] read_addr_q;
   logic [ADDR_W-1:0] write_addr_q;
   logic [DATA_W-1:0] write_data_q;

   logic              setup_d;
   logic              err_d;
   logic              enter_mem_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   logic              write_d;
   logic              xfer_err_d;

   // Strobes are registered, so they are loaded on the edge that enters MEM;
   // with no wait states that edge is the setup edge and uses the live bus.
   always_comb begin
      setup_d = apb.psel && !apb.penable;
      err_d   = 32'(apb.paddr) >= MEM_DEPTH;
      if (state_q == IDLE) begin
         addr_d      = apb.paddr;
         wdata_d     = apb.pwdata;
         write_d     = apb.pwrite;
         xfer_err_d  = err_d;
         enter_mem_d = setup_d && (WAIT_STATES == 0);
      end else begin
         addr_d      = addr_q;
         wdata_d     = wdata_q;
         write_d     = write_q;
         xfer_err_d  = err_q;
         enter_mem_d = (state_q == WAIT) && apb.psel && (cnt_q == CNT_W'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         err_q        <= 1'b0;
         pready_q     <= 1'b0;
         pslverr_q    <= 1'b0;
         prdata_q     <= '0;
         mem_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         read_addr_q  <= '0;
         write_addr_q <= '0;
         write_data_q <= '0;
      end else begin
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         if (enter_mem_d) begin
            read_addr_q  <= addr_d;
            write_addr_q <= addr_d;
            write_data_q <= wdata_d;
            mem_write_q  <= write_d && !xfer_err_d;
            mem_read_q   <= !write_d && !xfer_err_d;
         end
         case (state_q)
            IDLE: begin
               if (setup_d) begin
                  addr_q  <= apb.paddr;
                  wdata_q <= apb.pwdata;
                  write_q <= apb.pwrite;
                  err_q   <= err_d;
                  cnt_q   <= CNT_W'(WAIT_STATES);
                  state_q <= (WAIT_STATES == 0) ? MEM : WAIT;
               end
            end
            WAIT: begin
               if (!apb.psel) begin
                  state_q <= IDLE;
               end else if (cnt_q == CNT_W'(1)) begin
                  state_q <= MEM;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            MEM: begin
               state_q   <= RESP;
               pready_q  <= 1'b1;
               pslverr_q <= err_q;
               prdata_q  <= (!write_q && !err_q) ? read_data : '0;
            end
            RESP: begin
               state_q   <= IDLE;
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
               prdata_q  <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign apb.pready  = pready_q;
   assign apb.pslverr = pslverr_q;
   assign apb.prdata  = prdata_q;
   assign mem_write   = mem_write_q;
   assign mem_read    = mem_read_q;
   assign read_addr   = read_addr_q;
   assign write_addr  = write_addr_q;
   assign write_data  = write_data_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: default, MEM_DEPTH=128 and WAIT_STATES=0 instances.
module tb_apb_mem_slave;
   import apb_mem_pkg::*;

   typedef struct {
      int         d;
      bit         wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      int         exp_stb;
      int         exp_rdy;
      bit         exp_err;
      logic [7:0] exp_rdata;
   } vec_t;

   logic clk;
   logic rst;

   logic       psel_v    [3];
   logic       penable_v [3];
   logic       pwrite_v  [3];
   logic [7:0] paddr_v   [3];
   logic [7:0] pwdata_v  [3];
   logic       pready_v  [3];
   logic       pslverr_v [3];
   logic [7:0] prdata_v  [3];
   logic       mw_v      [3];
   logic       mr_v      [3];
   logic [7:0] raddr_v   [3];
   logic [7:0] waddr_v   [3];
   logic [7:0] wdat_v    [3];
   logic [7:0] rd_v      [3];
   logic [7:0] mem       [3][256];

   int errors;
   int checks;

   apb_mem_slave_if #(.ADDR_W(8), .DATA_W(8)) ifs [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_conn
      assign ifs[g].psel    = psel_v[g];
      assign ifs[g].penable = penable_v[g];
      assign ifs[g].pwrite  = pwrite_v[g];
      assign ifs[g].paddr   = paddr_v[g];
      assign ifs[g].pwdata  = pwdata_v[g];
      assign pready_v[g]    = ifs[g].pready;
      assign pslverr_v[g]   = ifs[g].pslverr;
      assign prdata_v[g]    = ifs[g].prdata;
      assign rd_v[g]        = mem[g][raddr_v[g]];
   end

   apb_mem_slave u_def (
      .clk(clk), .rst(rst), .apb(ifs[0]),
      .read_addr(raddr_v[0]), .write_addr(waddr_v[0]), .write_data(wdat_v[0]),
      .mem_write(mw_v[0]), .mem_read(mr_v[0]), .read_data(rd_v[0])
   );

   apb_mem_slave #(.MEM_DEPTH(128)) u_err (
      .clk(clk), .rst(rst), .apb(ifs[1]),
      .read_addr(raddr_v[1]), .write_addr(waddr_v[1]), .write_data(wdat_v[1]),
      .mem_write(mw_v[1]), .mem_read(mr_v[1]), .read_data(rd_v[1])
   );

   apb_mem_slave #(.WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst(rst), .apb(ifs[2]),
      .read_addr(raddr_v[2]), .write_addr(waddr_v[2]), .write_data(wdat_v[2]),
      .mem_write(mw_v[2]), .mem_read(mr_v[2]), .read_data(rd_v[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // datamem stand-in; location 0x80 of the MEM_DEPTH=128 copy holds a
   // non-zero byte so an errored read that leaks read_data is visible.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 256; j++) mem[i][j] <= '0;
         mem[1][128] <= 8'h77;
      end else begin
         for (int i = 0; i < 3; i++)
            if (mw_v[i]) mem[i][waddr_v[i]] <= wdat_v[i];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs(input int d);
      return {28'b0, pready_v[d], pslverr_v[d], prdata_v[d], mw_v[d], mr_v[d],
              raddr_v[d], waddr_v[d], wdat_v[d]};
   endfunction

   // Called just after a rising edge; T0 is the current cycle.  Returns just
   // after the edge that ends the pready cycle, ready for a back-to-back setup.
   task automatic run_vec(input vec_t v, input string tag);
      int         cyc, nstb, stb_cyc, rdy_cyc;
      bit         stb_wr, got_rdy;
      logic [7:0] stb_addr, stb_data, rd_s;
      logic       err_s;
      nstb = 0; stb_cyc = 0; rdy_cyc = 99; stb_wr = 0; got_rdy = 0;
      stb_addr = '0; stb_data = '0; rd_s = '0; err_s = 1'b0;
      psel_v[v.d] = 1'b1; penable_v[v.d] = 1'b0; pwrite_v[v.d] = v.wr;
      paddr_v[v.d] = v.addr; pwdata_v[v.d] = v.wdata;
      @(negedge clk);
      if (mw_v[v.d] || mr_v[v.d]) nstb++;
      @(posedge clk); #1;
      penable_v[v.d] = 1'b1;
      cyc = 1;
      while (!got_rdy && cyc <= 12) begin
         @(negedge clk);
         if (mw_v[v.d]) begin
            nstb++; stb_cyc = cyc; stb_wr = 1; stb_addr = waddr_v[v.d]; stb_data = wdat_v[v.d];
         end
         if (mr_v[v.d]) begin
            nstb++; stb_cyc = cyc; stb_wr = 0; stb_addr = raddr_v[v.d];
         end
         if (pready_v[v.d]) begin
            got_rdy = 1; rdy_cyc = cyc; err_s = pslverr_v[v.d]; rd_s = prdata_v[v.d];
         end
         @(posedge clk); #1;
         cyc++;
      end
      psel_v[v.d] = 1'b0; penable_v[v.d] = 1'b0;
      chk({tag, ".strobes"}, 64'(nstb), (v.exp_stb != 0) ? 64'd1 : 64'd0);
      if (v.exp_stb != 0) begin
         chk({tag, ".stb_cycle"}, 64'(stb_cyc), 64'(v.exp_stb));
         chk({tag, ".stb_kind"}, 64'(stb_wr), 64'(v.wr));
         chk({tag, ".stb_addr"}, 64'(stb_addr), 64'(v.addr));
         if (v.wr) chk({tag, ".stb_data"}, 64'(stb_data), 64'(v.wdata));
      end
      chk({tag, ".pready_cycle"}, 64'(rdy_cyc), 64'(v.exp_rdy));
      chk({tag, ".pslverr"}, 64'(err_s), 64'(v.exp_err));
      chk({tag, ".prdata"}, 64'(rd_s), 64'(v.exp_rdata));
   endtask

   vec_t vecs [10];
   vec_t v;
   int   nstb, nrdy;

   initial begin
      errors = 0;
      checks = 0;
      vecs[0] = '{0, 1'b1, 8'h10, 8'h3C, 2, 3, 1'b0, 8'h00};
      vecs[1] = '{0, 1'b0, 8'h10, 8'h00, 2, 3, 1'b0, 8'h3C};
      vecs[2] = '{0, 1'b1, 8'hFF, 8'hA5, 2, 3, 1'b0, 8'h00};
      vecs[3] = '{0, 1'b0, 8'hFF, 8'h00, 2, 3, 1'b0, 8'hA5};
      vecs[4] = '{1, 1'b1, 8'h80, 8'h11, 0, 3, 1'b1, 8'h00};
      vecs[5] = '{1, 1'b1, 8'h7F, 8'h5A, 2, 3, 1'b0, 8'h00};
      vecs[6] = '{1, 1'b0, 8'h7F, 8'h00, 2, 3, 1'b0, 8'h5A};
      vecs[7] = '{1, 1'b0, 8'h80, 8'h00, 0, 3, 1'b1, 8'h00};
      vecs[8] = '{2, 1'b1, 8'hFF, 8'hC3, 1, 2, 1'b0, 8'h00};
      vecs[9] = '{2, 1'b0, 8'hFF, 8'h00, 1, 2, 1'b0, 8'hC3};

      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         psel_v[i] = 1'b0; penable_v[i] = 1'b0; pwrite_v[i] = 1'b0;
         paddr_v[i] = '0; pwdata_v[i] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk($sformatf("reset.outs%0d", i), outs(i), 64'd0);
      chk("reset.state", 64'(u_def.state_q), 64'(IDLE));
      chk("reset.cnt", 64'(u_def.cnt_q), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Abort: psel dropped in the wait-state cycle.
      psel_v[0] = 1'b1; penable_v[0] = 1'b0; pwrite_v[0] = 1'b1;
      paddr_v[0] = 8'h30; pwdata_v[0] = 8'hEE;
      @(posedge clk); #1;
      psel_v[0] = 1'b0;
      nstb = 0; nrdy = 0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (mw_v[0] || mr_v[0]) nstb++;
         if (pready_v[0]) nrdy++;
         if (c == 2) chk("abort.state_T2", 64'(u_def.state_q), 64'(IDLE));
         @(posedge clk); #1;
      end
      chk("abort.strobes", 64'(nstb), 64'd0);
      chk("abort.pready", 64'(nrdy), 64'd0);
      v = '{0, 1'b0, 8'h30, 8'h00, 2, 3, 1'b0, 8'h00};
      run_vec(v, "abort.readback");

      // Reset asserted during the MEM cycle.
      psel_v[0] = 1'b1; penable_v[0] = 1'b0; pwrite_v[0] = 1'b1;
      paddr_v[0] = 8'h20; pwdata_v[0] = 8'h99;
      @(posedge clk); #1;
      penable_v[0] = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstmid.strobe_T2", 64'(mw_v[0]), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; psel_v[0] = 1'b0; penable_v[0] = 1'b0;
      @(negedge clk);
      chk("rstmid.outs_T3", outs(0), 64'd0);
      chk("rstmid.state_T3", 64'(u_def.state_q), 64'(IDLE));
      @(posedge clk); #1;
      v = '{0, 1'b1, 8'h21, 8'h42, 2, 3, 1'b0, 8'h00};
      run_vec(v, "rstmid.write");
      v = '{0, 1'b0, 8'h21, 8'h00, 2, 3, 1'b0, 8'h42};
      run_vec(v, "rstmid.read");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1);
   end

endmodule
